// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit holding the architectural HI/LO
// registers. MULT/MULTU use radix-2 shift-add; DIV/DIVU use restoring
// division. Both run 32 CALC cycles on magnitudes, then one FIX cycle that
// applies the sign correction and writes HI/LO.
//
// Handshake: start is accepted only on an IDLE edge without flush. Once
// accepted, busy stays high until the FIX edge; done pulses for one cycle
// after HI/LO take a new mult/div result. Callers must hold off
// MFHI/MFLO/MTHI/MTLO and new starts while busy (mthi/mtlo/start are ignored
// then).
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(WIDTH-1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;       // multiplicand / dividend (shifts left in div)
  logic [WIDTH-1:0]   b_q, b_d;       // multiplier (shifts right) / divisor
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // product, or {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot_neg, rem_neg;
  logic               fix_signed;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Operand magnitudes, per-cycle arithmetic and the FIX-cycle sign correction.
  always_comb begin
    a_abs      = a[WIDTH-1] ? (~a + ONE_W) : a;
    b_abs      = b[WIDTH-1] ? (~b + ONE_W) : b;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    div_shift  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    div_trial  = div_shift - {1'b0, b_q};
    div_ok     = ~div_trial[WIDTH];
    prod_neg   = ~acc_q + ONE_2W;
    quot_neg   = ~acc_q[WIDTH-1:0] + ONE_W;
    rem_neg    = ~acc_q[2*WIDTH-1:WIDTH] + ONE_W;
    fix_signed = ~op_q[0];
    if (op_q[1]) begin
      fix_lo = (fix_signed && (sa_q ^ sb_q)) ? quot_neg : acc_q[WIDTH-1:0];
      fix_hi = (fix_signed && sa_q) ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      {fix_hi, fix_lo} = (fix_signed && (sa_q ^ sb_q)) ? prod_neg : acc_q;
    end
  end

  // Next-state logic for the FSM, datapath and HI/LO.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mthi) hi_d = wd;
        if (mtlo) lo_d = wd;
        if (start && !flush) begin
          state_d = S_CALC;
          op_d    = op;
          acc_d   = '0;
          cnt_d   = '0;
          if (!op[0]) begin
            a_d  = a_abs;
            b_d  = b_abs;
            sa_d = a[WIDTH-1];
            sb_d = b[WIDTH-1];
          end else begin
            a_d  = a;
            b_d  = b;
            sa_d = 1'b0;
            sb_d = 1'b0;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            acc_d = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ok};
            a_d   = a_q << 1;
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            b_d   = b_q >> 1;
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_END) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized and directed stimulus for mdu_hilo. Expected HI/LO
// results come from a plain-arithmetic model and are queued at issue time; a
// monitor pops and compares on every done pulse.
module tb_mdu_hilo;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr, start, flush, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic [W-1:0] hi, lo;
  logic         busy, done;
  logic [1:0]   dbg_state;

  logic [63:0]  exp_q[$];
  logic [63:0]  mon_exp;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           done_cnt = 0;
  int           n_pushed = 0;
  logic [W-1:0] m_hi, m_lo;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wd(wd),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on the whole operands.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, rm;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin p = sx * sy; r = p; end
      2'd1: r = {32'b0, x} * {32'b0, y};
      2'd2: begin
        if (y == 0) r = {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q  = sx / sy;
          rm = sx % sy;
          r  = {rm[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!clr && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no pending result", hi, lo);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {hi, lo}, mon_exp);
      end
    end
  end

  // Drive start for one edge (called at a negedge). push=1 queues the result.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    logic [63:0] r;
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      r = ref_model(o, x, y);
      exp_q.push_back(r);
      n_pushed++;
      m_hi = r[63:32];
      m_lo = r[31:0];
    end
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  // Issue, count busy cycles, and check the done pulse width.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit chk_old);
    int n;
    logic [63:0] prev;
    prev = {m_hi, m_lo};
    issue(o, x, y, 1'b1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (chk_old && n == 33) check("hilo_before_fix", {hi, lo}, prev);
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'd33);
    check("done_high", 64'(done), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  int d0;

  // reset and stimulus
  initial begin
    clr = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; a = '0; b = '0; wd = '0;
    m_hi = '0; m_lo = '0;
    #3;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk); @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // directed arithmetic cases
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("multu_max_fixed", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);
    run_op(2'd3, 32'h1234, 32'd0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);

    // mthi then MULT, second start + mthi while busy, flush at cycle 10
    mthi = 1'b1; wd = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0; m_hi = 32'hA5A5_A5A5;
    check("mthi_idle", {hi, lo}, {m_hi, m_lo});
    d0 = done_cnt;
    issue(2'd0, $urandom, $urandom, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5; mthi = 1'b1; wd = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    check("flush_no_done", 64'(done_cnt), 64'(d0));

    // start with flush on the same edge stays idle
    start = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle", 64'(busy), 64'd0);

    // mthi and mtlo together
    mthi = 1'b1; mtlo = 1'b1; wd = 32'h0BAD_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    m_hi = 32'h0BAD_F00D; m_lo = 32'h0BAD_F00D;
    check("mthi_mtlo_both", {hi, lo}, {m_hi, m_lo});

    // start and mtlo on the same edge: result overwrites
    mtlo = 1'b1; wd = 32'hDEAD_BEEF;
    fork
      run_op(2'd3, 32'd1000, 32'd33, 1'b0);
      begin @(negedge clk); mtlo = 1'b0; end
    join

    // clr mid-DIV
    issue(2'd2, 32'hFFFF_0000, 32'd77, 1'b0);
    repeat (19) @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_hilo", {hi, lo}, 64'd0);
    check("clr_busy_done", {62'd0, busy, done}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    run_op(2'd1, 32'd6, 32'd7, 1'b0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
